// File: rtl/dac_source_sequencer_pkg.sv
// Shared types and constants for the DAC source sequencer: FSM state
// encoding, DAC drive levels and the width of the test-pattern index.
package dac_source_sequencer_pkg;

    localparam int COLOR_W = 3;

    localparam logic [7:0] COL_ON  = 8'hFF;
    localparam logic [7:0] COL_OFF = 8'h00;

    typedef enum logic [1:0] {
        ST_CORE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TEST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Full-scale or zero drive for one pattern channel.
    function automatic logic [7:0] pattern_level(input logic i_on);
        return i_on ? COL_ON : COL_OFF;
    endfunction

endpackage

// File: rtl/dac_dwell_timer.sv
// Frame counter for the test pattern: counts frame starts while the
// pattern runs and pulses o_advance on the frame that ends a colour's dwell.
module dac_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic               i_clear,
    input  logic               i_fs,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_advance
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_last;

    // Last count of a dwell; a dwell of 0 behaves as 1, so the last count is 0.
    // Comparing with >= lets a live-lowered dwell advance at the next frame.
    assign w_last    = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
    assign o_advance = i_run && i_fs && (r_cnt >= w_last);

    // Frame counter: cleared on mode entry/exit, wraps at the end of each dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && i_fs) begin
            r_cnt <= o_advance ? '0 : r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/dac_source_sequencer.sv
// Frame-synchronous selector between core video and an eight-colour DAC
// test pattern. Source switches only on a frame start; all DAC-side
// outputs are registered and move together.
module dac_source_sequencer
    import dac_source_sequencer_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               CLK_24M,
    input  logic               nRESET,
    input  logic [7:0]         CORE_R,
    input  logic [7:0]         CORE_G,
    input  logic [7:0]         CORE_B,
    input  logic               CORE_BLANK,
    input  logic               VSYNC_N,
    input  logic               TEST_REQ,
    input  logic [DWELL_W-1:0] TEST_DWELL,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               TEST_ACTIVE,
    output logic [COLOR_W-1:0] TEST_COLOR
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W-1:0] w_color_nxt;
    logic               r_vsync_prev;
    logic               w_fs;
    logic               w_enter_test;
    logic               w_leave_drain;
    logic               w_timer_run;
    logic               w_timer_clear;
    logic               w_advance;
    logic               w_pattern;

    // Frame start: first low cycle of VSYNC_N. The history register resets
    // low, so a VSYNC_N already low at reset release is not a frame start.
    assign w_fs = !VSYNC_N && r_vsync_prev;

    assign w_enter_test  = TEST_REQ && w_fs && ((r_state == ST_CORE) || (r_state == ST_ARM));
    assign w_leave_drain = !TEST_REQ && w_fs && (r_state == ST_DRAIN);
    assign w_timer_clear = w_enter_test || w_leave_drain;
    // Leaving TEST in the same cycle as a frame start must not advance.
    assign w_timer_run   = (r_state == ST_TEST) && TEST_REQ;

    dac_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk       (CLK_24M),
        .rst_n     (nRESET),
        .i_run     (w_timer_run),
        .i_clear   (w_timer_clear),
        .i_fs      (w_fs),
        .i_dwell   (TEST_DWELL),
        .o_advance (w_advance)
    );

    // Next state and next colour index.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        w_color_nxt = r_color;
        unique case (r_state)
            ST_CORE: begin
                if (w_enter_test)  w_state_nxt = ST_TEST;
                else if (TEST_REQ) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!TEST_REQ)         w_state_nxt = ST_CORE;
                else if (w_enter_test) w_state_nxt = ST_TEST;
            end
            ST_TEST: begin
                if (!TEST_REQ)      w_state_nxt = ST_DRAIN;
                else if (w_advance) w_color_nxt = r_color + COLOR_W'(1);
            end
            ST_DRAIN: begin
                if (TEST_REQ)           w_state_nxt = ST_TEST;
                else if (w_leave_drain) w_state_nxt = ST_CORE;
            end
            default: w_state_nxt = ST_CORE;
        endcase
        if (w_timer_clear) w_color_nxt = '0;
    end

    assign w_pattern = (w_state_nxt == ST_TEST) || (w_state_nxt == ST_DRAIN);

    // FSM state, colour, sync history and registered DAC drive, all on one edge.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= ST_CORE;
            r_color      <= '0;
            r_vsync_prev <= 1'b0;
            VGA_R        <= COL_OFF;
            VGA_G        <= COL_OFF;
            VGA_B        <= COL_OFF;
            TEST_ACTIVE  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_color      <= w_color_nxt;
            r_vsync_prev <= VSYNC_N;
            TEST_ACTIVE  <= w_pattern;
            if (CORE_BLANK) begin
                VGA_R <= COL_OFF;
                VGA_G <= COL_OFF;
                VGA_B <= COL_OFF;
            end else if (w_pattern) begin
                VGA_R <= pattern_level(w_color_nxt[0]);
                VGA_G <= pattern_level(w_color_nxt[1]);
                VGA_B <= pattern_level(w_color_nxt[2]);
            end else begin
                VGA_R <= CORE_R;
                VGA_G <= CORE_G;
                VGA_B <= CORE_B;
            end
        end
    end

    // The colour register is already aligned with the other DAC-side outputs.
    assign TEST_COLOR = r_color;

endmodule

// File: doc/dac_source_sequencer.md
# dac_source_sequencer

Selects what drives the VGA DAC: live core video or an eight-colour DAC test pattern. Switching between sources happens only at a frame boundary. In test mode the block steps through the colours, holding each one for a programmable number of frames. It sits between the video output stage and the VGA_R/G/B pins, so it replaces the free-running tester with a frame-synchronous, requestable one.

## Interface
- DWELL_W, 8, width of the frames-per-colour setting and the internal frame counter.

- CLK_24M  in  1  system clock; all logic on its rising edge.
- nRESET  in  1  reset, asynchronous assert, active-low.
- CORE_R / CORE_G / CORE_B  in  8 each  core video colour.
- CORE_BLANK  in  1  high = blanking interval; forces black output.
- VSYNC_N  in  1  active-low vertical sync, CLK_24M domain.
- TEST_REQ  in  1  level request for test-pattern mode.
- TEST_DWELL  in  DWELL_W  frames per colour; 0 is treated as 1.
- VGA_R / VGA_G / VGA_B  out  8 each  registered DAC drive.
- TEST_ACTIVE  out  1  high while the pattern is on the outputs; aligned with VGA_*.
- TEST_COLOR  out  3  current pattern index; aligned with VGA_*.

## Operation
- Frame start (fs): VSYNC_N is low this cycle and was high last cycle. The previous-value register resets to 0, so reset release never produces a false fs.
- States: CORE, ARM, TEST, DRAIN.
  - CORE: if TEST_REQ and fs → TEST; else if TEST_REQ → ARM.
  - ARM: if !TEST_REQ → CORE; else if fs → TEST.
  - TEST: if !TEST_REQ → DRAIN. Otherwise run the dwell logic below.
  - DRAIN: if TEST_REQ → TEST (cancels the exit; colour and counter kept); else if fs → CORE.
- Entering TEST from CORE or ARM clears the colour index and the frame counter to 0.
- Leaving DRAIN for CORE also clears the colour index and the frame counter to 0.
- Dwell logic, applied on fs in TEST only:
  - dwell_eff = (TEST_DWELL == 0) ? 1 : TEST_DWELL.
  - If cnt >= dwell_eff − 1: cnt ← 0 and colour ← colour + 1, wrapping 7 → 0 (3-bit modular).
  - Otherwise cnt ← cnt + 1.
  - TEST_DWELL is sampled live. Lowering it below cnt+1 advances the colour at the next fs; no underflow.
- Frame counter does not advance in DRAIN; colour is held.
- Source select:
  - CORE and ARM pass CORE_*.
  - TEST and DRAIN drive the pattern: R = colour[0] ? FF : 00, G = colour[1] ? FF : 00, B = colour[2] ? FF : 00.
- CORE_BLANK high forces VGA_* to 00 in every state.
- Simultaneous events:
  - fs and a TEST_REQ change in the same cycle: the state decision uses that cycle's sampled TEST_REQ.
  - fs arriving in the cycle TEST → DRAIN is taken: no colour advance.

## Timing
- Reset values: VGA_R/G/B = 00, TEST_ACTIVE = 0, TEST_COLOR = 0, state CORE, cnt = 0.
- Reset mid-frame or mid-test returns to CORE immediately; no fs is needed.
- Latency:
  - CORE_*/CORE_BLANK → VGA_*: exactly 1 cycle.
  - State or colour change → VGA_*, TEST_ACTIVE, TEST_COLOR: 1 cycle.
  - All three outputs change on the same edge.
- The source change is visible on the edge after the fs cycle, i.e. 1 cycle after VSYNC_N first reads low. Source never changes mid-frame.
- Minimum time in ARM is 0 cycles, when TEST_REQ and fs coincide.

## Structure
- Shared package holds:
  - the state enum (CORE/ARM/TEST/DRAIN, 2-bit);
  - colour constants COL_ON = 8'hFF and COL_OFF = 8'h00;
  - the pattern-index width (3).
- One sub-module: dac_dwell_timer, which holds the frame counter and the dwell_eff compare. Inputs: clk, reset, run, clear, fs, dwell. Output: advance pulse.
- Top level holds: fs detect, FSM, colour register, output mux/registers.

## Test plan
- Reset release with VSYNC_N held low → no fs; VGA_* = 00 then tracks CORE_* (for example 12/34/56) with 1-cycle latency; TEST_ACTIVE = 0.
- TEST_REQ rises mid-frame with TEST_DWELL = 2 → ARM, core video continues.
  - At the next fs, the following edge shows 00/00/00 with TEST_COLOR = 0.
  - After 2 more fs the output becomes FF/00/00 with TEST_COLOR = 1.
- TEST_DWELL = 0, 9 fs in TEST → one colour step per frame, sequence 0..7 then wrap to 0; final output 00/00/00 with TEST_COLOR = 0.
- TEST_REQ drops → DRAIN keeps the pattern with colour frozen.
  - Re-assert before the next fs → TEST resumes with the same colour.
  - Drop again and let fs occur → CORE next edge; TEST_ACTIVE = 0; colour reset to 0.
- CORE_BLANK high in both CORE and TEST → VGA_* = 00 one cycle later; TEST_COLOR is unaffected.
- TEST_REQ pulses for 3 cycles with no fs → ARM → CORE; outputs never leave core video.
